// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared DNN datapath constants and argmax state encoding
package dnn_pkg;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } argmax_state_t;
endpackage

// File: rtl/stream_argmax_if.sv
// rtl/stream_argmax_if.sv - run control, element stream and result bundle for stream_argmax (STREAM_ARGMAX_MIN_EN adds min_sel)
interface stream_argmax_if;
    import dnn_pkg::*;

    logic              start;
    logic [IDX_W-1:0]  len;
    logic              u_mod;
`ifdef STREAM_ARGMAX_MIN_EN
    logic              min_sel;
`endif
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]  max_idx;
    logic              busy;

    modport master (
`ifdef STREAM_ARGMAX_MIN_EN
        output min_sel,
`endif
        output start, len, u_mod, in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_val, max_idx, busy
    );

    modport slave (
`ifdef STREAM_ARGMAX_MIN_EN
        input  min_sel,
`endif
        input  start, len, u_mod, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_val, max_idx, busy
    );
endinterface

// File: rtl/lt32.sv
// rtl/lt32.sv - less-than comparator with per-run signed/unsigned ordering
module lt32
    import dnn_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              u_mod,
    output logic              lt
);
    logic magLess;
    logic signDiffer;

    assign magLess    = (a < b);
    assign signDiffer = (a[DATA_W-1] != b[DATA_W-1]);

    // Differing sign bits: the negative operand is the smaller one.
    assign lt = (!u_mod && signDiffer) ? a[DATA_W-1] : magLess;
endmodule

// File: rtl/stream_argmax.sv
// rtl/stream_argmax.sv - streaming max finder reporting largest element and index (optional argmin via STREAM_ARGMAX_MIN_EN)
module stream_argmax
    import dnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    stream_argmax_if.slave   bus
);
    argmax_state_t     state;
    argmax_state_t     nextState;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  lenQ;
    logic              uModQ;
    logic              minSelQ;
    logic              minSelIn;
    logic [DATA_W-1:0] maxVal;
    logic [IDX_W-1:0]  maxIdx;
    logic [DATA_W-1:0] cmpA;
    logic [DATA_W-1:0] cmpB;
    logic              cmpLess;
    logic              beat;
    logic              lastBeat;
    logic              replace;
    logic              startOk;
    logic              inReady;
    logic              outValid;
    logic              busyQ;

`ifdef STREAM_ARGMAX_MIN_EN
    assign minSelIn = bus.min_sel;
`else
    assign minSelIn = 1'b0;
`endif

    assign startOk  = (state == IDLE) && bus.start && (bus.len != '0);
    assign beat     = (state == RUN) && bus.in_valid;
    assign lastBeat = (cnt == lenQ - IDX_W'(1));

    // Argmin swaps the operands so one comparator serves both directions.
    assign cmpA = minSelQ ? bus.in_data : maxVal;
    assign cmpB = minSelQ ? maxVal : bus.in_data;

    lt32 uLt (
        .a    (cmpA),
        .b    (cmpB),
        .u_mod(uModQ),
        .lt   (cmpLess)
    );

    // Strict less-than keeps the earlier index on ties.
    assign replace = (cnt == '0) || cmpLess;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        busyQ     = 1'b0;
        case (state)
            IDLE: begin
                if (startOk) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                inReady = 1'b1;
                busyQ   = 1'b1;
                if (beat && lastBeat) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                busyQ    = 1'b1;
                if (bus.out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            lenQ    <= '0;
            uModQ   <= 1'b0;
            minSelQ <= 1'b0;
            maxVal  <= '0;
            maxIdx  <= '0;
        end else if (startOk) begin
            cnt     <= '0;
            lenQ    <= bus.len;
            uModQ   <= bus.u_mod;
            minSelQ <= minSelIn;
        end else if (beat) begin
            cnt <= cnt + IDX_W'(1);
            if (replace) begin
                maxVal <= bus.in_data;
                maxIdx <= cnt;
            end
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.busy      = busyQ;
    assign bus.max_val   = maxVal;
    assign bus.max_idx   = maxIdx;
endmodule

// File: tb/tb_stream_argmax.sv
// tb/tb_stream_argmax.sv - scoreboard bench for stream_argmax (STREAM_ARGMAX_MIN_EN adds an argmin run)
module tb_stream_argmax;
    import dnn_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [DATA_W+IDX_W-1:0] sb[$];

    stream_argmax_if bus();

    stream_argmax dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: compares each handshaken result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h/%0h expected none", bus.max_val, bus.max_idx);
            end else begin
                logic [DATA_W+IDX_W-1:0] e;
                e = sb.pop_front();
                check("result_val", 64'(bus.max_val), 64'(e[DATA_W+IDX_W-1:IDX_W]));
                check("result_idx", 64'(bus.max_idx), 64'(e[IDX_W-1:0]));
            end
        end
    end

    task automatic doStart(input logic [IDX_W-1:0] l, input logic um);
        @(posedge clk) #1;
        bus.start = 1'b1;
        bus.len   = l;
        bus.u_mod = um;
        @(posedge clk) #1;
        bus.start = 1'b0;
        check("in_ready_after_start", 64'(bus.in_ready), 64'(l != 0));
    endtask

    task automatic sendBeat(input logic [DATA_W-1:0] d, input int gap);
        repeat (gap) @(posedge clk) #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_ready: got 0 expected 1");
        end
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic finishRun(input int hold, input logic [DATA_W-1:0] expVal);
        int waited;
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(posedge clk) #1;
            waited++;
        end
        check("out_valid_present", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_val", 64'(bus.max_val), 64'(expVal));
        end
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        bus.out_ready = 1'b0;
        check("idle_after_hs_busy", 64'(bus.busy), 64'd0);
        check("idle_after_hs_valid", 64'(bus.out_valid), 64'd0);
    endtask

    function automatic logic [DATA_W+IDX_W-1:0] exp2(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] i);
        return {v, i};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.u_mod = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
`ifdef STREAM_ARGMAX_MIN_EN
        bus.min_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_max_val", 64'(bus.max_val), 64'd0);
        check("rst_max_idx", 64'(bus.max_idx), 64'd0);
        rst_n = 1'b1;

        // Unsigned with duplicated maximum: earliest index wins.
        sb.push_back(exp2(32'hFFFF_FFFF, 16'd1));
        doStart(16'd4, 1'b1);
        sendBeat(32'd5, 0);
        sendBeat(32'hFFFF_FFFF, 0);
        sendBeat(32'd7, 0);
        check("t1_no_early_valid", 64'(bus.out_valid), 64'd0);
        sendBeat(32'hFFFF_FFFF, 0);
        check("t1_valid_after_last", 64'(bus.out_valid), 64'd1);
        check("t1_ready_after_last", 64'(bus.in_ready), 64'd0);
        check("t1_val_visible", 64'(bus.max_val), 64'hFFFF_FFFF);
        finishRun(0, 32'hFFFF_FFFF);

        // Signed vs unsigned ordering on the same data.
        sb.push_back(exp2(32'd2, 16'd2));
        doStart(16'd3, 1'b0);
        sendBeat(32'hFFFF_FFFF, 0);
        sendBeat(32'h8000_0000, 0);
        sendBeat(32'd2, 0);
        finishRun(0, 32'd2);
        sb.push_back(exp2(32'hFFFF_FFFF, 16'd0));
        doStart(16'd3, 1'b1);
        sendBeat(32'hFFFF_FFFF, 0);
        sendBeat(32'h8000_0000, 0);
        sendBeat(32'd2, 0);
        finishRun(0, 32'hFFFF_FFFF);

        // Single element run: result two cycles after start.
        sb.push_back(exp2(32'h8000_0000, 16'd0));
        doStart(16'd1, 1'b0);
        sendBeat(32'h8000_0000, 0);
        check("t3_len1_valid", 64'(bus.out_valid), 64'd1);
        finishRun(0, 32'h8000_0000);

        // Zero-length start is ignored.
        doStart(16'd0, 1'b1);
        check("t4_len0_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_len0_no_valid", 64'(bus.out_valid), 64'd0);
        check("t4_len0_no_ready", 64'(bus.in_ready), 64'd0);

        // Start pulsed mid-run must not disturb it.
        sb.push_back(exp2(32'd9, 16'd1));
        doStart(16'd3, 1'b1);
        sendBeat(32'd1, 0);
        bus.start = 1'b1;
        bus.len = 16'd5;
        @(posedge clk) #1;
        bus.start = 1'b0;
        sendBeat(32'd9, 0);
        sendBeat(32'd4, 0);
        check("t5_mid_start_done", 64'(bus.out_valid), 64'd1);
        finishRun(0, 32'd9);

        // Input gaps and output back-pressure.
        sb.push_back(exp2(32'd10, 16'd1));
        doStart(16'd4, 1'b0);
        sendBeat(32'hFFFF_FFFD, 2);
        sendBeat(32'd10, 0);
        sendBeat(32'hFFFF_FFEC, 3);
        sendBeat(32'd10, 1);
        finishRun(5, 32'd10);

        // Asynchronous reset mid-run discards the partial result.
        doStart(16'd6, 1'b1);
        sendBeat(32'd50, 0);
        sendBeat(32'd60, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_val", 64'(bus.max_val), 64'd0);
        check("t7_rst_idx", 64'(bus.max_idx), 64'd0);
        check("t7_rst_busy", 64'(bus.busy), 64'd0);
        check("t7_rst_ready", 64'(bus.in_ready), 64'd0);
        check("t7_rst_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        check("t7_idle_after_rst", 64'(bus.in_ready), 64'd0);

        sb.push_back(exp2(32'd3, 16'd0));
        doStart(16'd3, 1'b1);
        sendBeat(32'd3, 0);
        sendBeat(32'd1, 0);
        sendBeat(32'd1, 0);
        finishRun(0, 32'd3);

`ifdef STREAM_ARGMAX_MIN_EN
        // Argmin with a tie on the minimum.
        sb.push_back(exp2(32'd1, 16'd1));
        bus.min_sel = 1'b1;
        doStart(16'd3, 1'b1);
        bus.min_sel = 1'b0;
        sendBeat(32'd3, 0);
        sendBeat(32'd1, 0);
        sendBeat(32'd1, 0);
        finishRun(0, 32'd1);
`endif

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_argmax.md
# stream_argmax

Sequential max-finder for the DNN datapath: accepts a stream of 32-bit elements over a valid/ready handshake and reports the largest element and its index. Signed or unsigned ordering is selected per run. It consumes the same less-than ordering the datapath comparator produces. It feeds classification (final-layer argmax) and max-pool reduction.

## Interface
- `DATA_W`, 32, element width.
- `IDX_W`, 16, index/length width; a run holds at most 2^IDX_W−1 elements.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a run; sampled only in IDLE.
- `len` input IDX_W: number of elements in the run; sampled with `start`.
- `u_mod` input 1: 1 = unsigned, 0 = signed two's complement; sampled with `start`.
- `in_valid` input 1: element present.
- `in_data` input DATA_W: element.
- `in_ready` output 1: element accepted when `in_valid` && `in_ready`.
- `out_valid` output 1: result available.
- `out_ready` input 1: result consumed when `out_valid` && `out_ready`.
- `max_val` output DATA_W: largest element.
- `max_idx` output IDX_W: 0-based index of the largest element.
- `busy` output 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: `start` && `len`≠0 → RUN. Latch `len` and `u_mod`; clear `cnt`.
  - RUN: on each accepted beat, `cnt`++. If `cnt`==`len`−1 on that beat → DONE.
  - DONE: `out_valid`=1; `out_ready` → IDLE.
- `start` with `len`==0 is ignored; stay in IDLE and produce no result.
- `start` in RUN or DONE is ignored.
- Beat 0 loads `max_val`=`in_data`, `max_idx`=0 unconditionally.
- Later beats replace the best only if best < `in_data` under the latched mode.
  - Ties keep the earlier index.
- Ordering rules:
  - Unsigned: plain magnitude.
  - Signed: MSB-set values are less than MSB-clear values; otherwise compare by magnitude.
- `in_ready`=1 exactly in RUN and is combinational from state only.
- `max_val`/`max_idx` are stable from DONE entry until IDLE. In IDLE they hold the previous result.

## Timing
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `busy`=0, `max_val`=0, `max_idx`=0, `cnt`=0.
- `start` accepted at edge t → `in_ready`=1 from t+1.
- Last beat accepted at edge t → `out_valid`=1 and `in_ready`=0 from t+1. The best-value update for that beat is visible at t+1.
- Minimum run: start → out_valid in `len`+1 cycles when `in_valid` is held high.
- Back-pressure: `in_valid` low stalls RUN indefinitely with no state change.
- `out_valid` holds until `out_ready`. Handshake at edge t → IDLE at t+1, and a new `start` is accepted at the earliest at t+1.
- `out_ready` high when `out_valid` is low has no effect.
- `rst_n` low at any point, mid-run included: immediate return to reset values. Any partial result is discarded.

## Configuration
- `STREAM_ARGMAX_MIN_EN` defined:
  - Adds input `min_sel` (1 bit), sampled with `start`.
  - When `min_sel`=1, replacement occurs if `in_data` < best, making the block an argmin. Ties still keep the earlier index.
- Undefined: no `min_sel` port; argmax only.

## Structure
- Shared package `dnn_pkg`:
  - `DATA_W` constant.
  - State enum `argmax_state_t` {IDLE, RUN, DONE}.
- One combinational sub-module `lt32`:
  - Ports: `a`, `b`, `u_mod` → `lt`.
  - Implements the signed/unsigned ordering above.
  - Instantiated once, with a = best and b = `in_data` (operands swapped under min mode).

## Test plan
- Unsigned, `len`=4, data {5, 0xFFFFFFFF, 7, 0xFFFFFFFF} → `max_val`=0xFFFFFFFF, `max_idx`=1 (tie keeps first); `out_valid` one cycle after 4th beat.
- Signed, `len`=3, data {0xFFFFFFFF, 0x80000000, 0x00000002} → `max_val`=2, `max_idx`=2. Same data unsigned → `max_val`=0xFFFFFFFF, `max_idx`=0.
- `len`=1, data {0x80000000}, signed → `max_val`=0x80000000, `max_idx`=0, `out_valid` 2 cycles after `start`.
- `start` with `len`=0 → state stays IDLE, `in_ready`=0, no `out_valid`. Also: `start` pulsed during RUN → ignored, run completes normally.
- Random `in_valid` gaps and `out_ready` held low 5 cycles → result unchanged while held; IDLE the cycle after handshake.
- `rst_n` asserted after 2 of 6 beats → all outputs zero immediately. A fresh 3-element run then gives the correct result. With `STREAM_ARGMAX_MIN_EN` and `min_sel`=1, data {3, 1, 1} → `max_val`=1, `max_idx`=1.
